// File: rtl/win_check_sequencer.sv
// Win detector: after each drop, walks four line directions outward from the dropped
// cell through the board RAM and reports whether a run of WIN_LEN was completed.
module win_check_sequencer #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       CHECK_FOR_WINNER,
  input  logic [2:0] LAST_COL,
  input  logic [2:0] LAST_ROW,
  input  logic       TURN,
  output logic       RD_EN,
  output logic [2:0] RD_COL,
  output logic [2:0] RD_ROW,
  input  logic [1:0] RD_DATA,
  output logic       BUSY,
  output logic       DONE_CHECK_WINNER,
  output logic       HAS_WON,
  output logic [2:0] dbg_state
);

  // Handshake: CHECK_FOR_WINNER is a one-cycle request honoured only while idle (BUSY=0);
  // DONE_CHECK_WINNER pulses once per accepted request and HAS_WON is valid from that
  // pulse until the next accepted request. RD_DATA answers the RD_EN of the previous cycle.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_STEP  = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic signed [3:0] COLS_S  = 4'(COLS);
  localparam logic signed [3:0] ROWS_S  = 4'(ROWS);
  localparam logic        [3:0] WIN_U   = 4'(WIN_LEN);

  state_t            state;
  logic [2:0]        last_col;
  logic [2:0]        last_row;
  logic [1:0]        code;
  logic [1:0]        dir;
  logic              side_neg;
  logic [3:0]        count;
  logic signed [3:0] cur_col;
  logic signed [3:0] cur_row;
  logic              has_won_q;
  logic              busy_q;
  logic              done_q;

  logic signed [3:0] dc;
  logic signed [3:0] dr;
  logic signed [3:0] nxt_col;
  logic signed [3:0] nxt_row;
  logic              in_bounds;
  logic              hit;
  logic              end_side;
  logic              last_side;
  logic              illegal;

  always_comb begin
    dc = 4'sd0;
    dr = 4'sd0;
    case (dir)
      2'd0:    begin dc = 4'sd1;  dr = 4'sd0; end
      2'd1:    begin dc = 4'sd0;  dr = 4'sd1; end
      2'd2:    begin dc = 4'sd1;  dr = 4'sd1; end
      default: begin dc = -4'sd1; dr = 4'sd1; end
    endcase
    nxt_col   = side_neg ? (cur_col - dc) : (cur_col + dc);
    nxt_row   = side_neg ? (cur_row - dr) : (cur_row + dr);
    in_bounds = (nxt_col >= 4'sd0) && (nxt_col < COLS_S) &&
                (nxt_row >= 4'sd0) && (nxt_row < ROWS_S);
    hit       = (RD_DATA == code);
    // A side ends on stepping off the board or on reading a cell that is not ours.
    end_side  = ((state == S_STEP) && !in_bounds) || ((state == S_CMP) && !hit);
    last_side = side_neg && (dir == 2'd3);
    illegal   = ({1'b0, last_col} >= 4'(COLS)) || ({1'b0, last_row} >= 4'(ROWS));
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      last_col  <= 3'd0;
      last_row  <= 3'd0;
      code      <= 2'b01;
      dir       <= 2'd0;
      side_neg  <= 1'b0;
      count     <= 4'd1;
      cur_col   <= 4'sd0;
      cur_row   <= 4'sd0;
      has_won_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (CHECK_FOR_WINNER) begin
            last_col  <= LAST_COL;
            last_row  <= LAST_ROW;
            code      <= TURN ? 2'b10 : 2'b01;
            has_won_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (illegal) begin
            has_won_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            dir      <= 2'd0;
            side_neg <= 1'b0;
            count    <= 4'd1;
            cur_col  <= signed'({1'b0, last_col});
            cur_row  <= signed'({1'b0, last_row});
            state    <= S_STEP;
          end
        end
        S_STEP: begin
          if (in_bounds) state <= S_CMP;
        end
        S_CMP: begin
          if (hit) begin
            count   <= count + 4'd1;
            cur_col <= nxt_col;
            cur_row <= nxt_row;
            if (count + 4'd1 == WIN_U) begin
              has_won_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_STEP;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Switching to the '-' side keeps count so both halves of a line add up.
      if (end_side) begin
        if (last_side) begin
          has_won_q <= 1'b0;
          done_q    <= 1'b1;
          state     <= S_DONE;
        end else begin
          state    <= S_STEP;
          side_neg <= !side_neg;
          cur_col  <= signed'({1'b0, last_col});
          cur_row  <= signed'({1'b0, last_row});
          if (side_neg) begin
            dir   <= dir + 2'd1;
            count <= 4'd1;
          end
        end
      end
    end
  end

  assign RD_EN             = (state == S_STEP) && in_bounds;
  assign RD_COL            = RD_EN ? nxt_col[2:0] : 3'd0;
  assign RD_ROW            = RD_EN ? nxt_row[2:0] : 3'd0;
  assign BUSY              = busy_q;
  assign DONE_CHECK_WINNER = done_q;
  assign HAS_WON           = has_won_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_win_check_sequencer.sv
// Bench for win_check_sequencer: board RAM model, line-walk reference model,
// directed scenarios and randomized boards.
module tb_win_check_sequencer;
  localparam int COLS    = 7;
  localparam int ROWS    = 6;
  localparam int WIN_LEN = 4;
  localparam int W       = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       check = 1'b0;
  logic [2:0] last_col = 3'd0;
  logic [2:0] last_row = 3'd0;
  logic       turn = 1'b0;
  logic       rd_en;
  logic [2:0] rd_col;
  logic [2:0] rd_row;
  logic [1:0] rd_data = 2'b00;
  logic       busy;
  logic       done;
  logic       has_won;
  logic [2:0] dbg_state;

  logic [1:0] board [0:COLS-1][0:ROWS-1];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  int checks = 0;
  int errors = 0;
  int obs_lat;
  logic obs_won;

  win_check_sequencer #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .CHECK_FOR_WINNER(check),
    .LAST_COL(last_col), .LAST_ROW(last_row), .TURN(turn),
    .RD_EN(rd_en), .RD_COL(rd_col), .RD_ROW(rd_row), .RD_DATA(rd_data),
    .BUSY(busy), .DONE_CHECK_WINNER(done), .HAS_WON(has_won), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Board RAM: data for a read strobe is presented before the following rising edge.
  always @(negedge clk) begin
    if (rd_en && rd_col < COLS && rd_row < ROWS) rd_data = board[rd_col][rd_row];
  end

  task automatic clear_board();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) board[c][r] = 2'b00;
  endtask

  // Reference: walk each line by plain coordinate arithmetic, listing the reads made.
  task automatic model(input int lc, input int lr, input logic t,
                       output int lat, output logic won);
    int dcs[4] = '{1, 0, 1, -1};
    int drs[4] = '{0, 1, 1, 1};
    int code, nreads, noob, cnt, c, r, s;
    exp_q.delete();
    won = 1'b0; nreads = 0; noob = 0;
    if (lc >= COLS || lr >= ROWS) begin
      lat = 2;
      return;
    end
    code = t ? 2 : 1;
    for (int d = 0; d < 4 && !won; d++) begin
      cnt = 1;
      for (int si = 0; si < 2 && !won; si++) begin
        s = (si == 0) ? 1 : -1;
        for (int k = 1; k < 8; k++) begin
          c = lc + s * dcs[d] * k;
          r = lr + s * drs[d] * k;
          if (c < 0 || c >= COLS || r < 0 || r >= ROWS) begin
            noob++;
            break;
          end
          exp_q.push_back({c[2:0], r[2:0]});
          nreads++;
          if (int'(board[c][r]) == code) begin
            cnt++;
            if (cnt == WIN_LEN) begin
              won = 1'b1;
              break;
            end
          end else begin
            break;
          end
        end
      end
    end
    lat = 2 + 2 * nreads + noob;
  endtask

  // Driver + monitor for one check; compares against the model. extra>0 re-pulses the start mid-scan.
  task automatic run_scan(input string name, input int lc, input int lr,
                          input logic t, input int extra);
    int exp_lat, cyc, busy_bad, extra_done;
    logic exp_won, held;
    model(lc, lr, t, exp_lat, exp_won);
    got_q.delete();
    last_col = lc[2:0]; last_row = lr[2:0]; turn = t;
    check = 1'b1;
    cyc = 0; busy_bad = 0; obs_lat = -1; obs_won = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check = 1'b0;
      if (extra > 0 && cyc == extra) check = 1'b1;
      if (extra > 0 && cyc == extra + 1) check = 1'b0;
      if (rd_en) got_q.push_back({rd_col, rd_row});
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        obs_lat = cyc;
        obs_won = has_won;
        break;
      end
    end
    check = 1'b0;
    checks++;
    if (obs_lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, obs_lat, exp_lat);
    end
    checks++;
    if (obs_won !== exp_won) begin
      errors++;
      $display("FAIL %s has_won: got %0b want %0b", name, obs_won, exp_won);
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL %s reads: got %p want %p", name, got_q, exp_q);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy: low in %0d scan cycles, want 0", name, busy_bad);
    end
    held = has_won;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || has_won !== exp_won) begin
      errors++;
      $display("FAIL %s after_done: done=%0b busy=%0b has_won=%0b want 0 0 %0b",
               name, done, busy, has_won, exp_won);
    end
    if (extra > 0) begin
      extra_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1) extra_done++;
      end
      checks++;
      if (extra_done != 0 || has_won !== held) begin
        errors++;
        $display("FAIL %s extra_start: extra dones %0d want 0, has_won %0b want %0b",
                 name, extra_done, has_won, held);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || has_won !== 1'b0 ||
        rd_col !== 3'd0 || rd_row !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_en=%0b busy=%0b done=%0b won=%0b col=%0d row=%0d want all 0",
               rd_en, busy, done, has_won, rd_col, rd_row);
    end
  endtask

  task automatic test_empty();
    logic [W-1:0] want[$];
    want = '{ {3'd1, 3'd0}, {3'd0, 3'd1}, {3'd1, 3'd1} };
    clear_board();
    run_scan("empty", 0, 0, 1'b0, 0);
    checks++;
    if (obs_lat !== 13 || obs_won !== 1'b0 || got_q != want) begin
      errors++;
      $display("FAIL empty_directed: lat=%0d won=%0b reads=%p want 13 0 %p",
               obs_lat, obs_won, got_q, want);
    end
  endtask

  task automatic test_vertical();
    logic [W-1:0] want[$];
    want = '{ {3'd4, 3'd3}, {3'd2, 3'd3}, {3'd3, 3'd4},
              {3'd3, 3'd2}, {3'd3, 3'd1}, {3'd3, 3'd0} };
    clear_board();
    board[3][0] = 2'b01; board[3][1] = 2'b01; board[3][2] = 2'b01; board[3][3] = 2'b01;
    run_scan("vertical", 3, 3, 1'b0, 0);
    checks++;
    if (obs_lat !== 14 || obs_won !== 1'b1 || got_q != want) begin
      errors++;
      $display("FAIL vertical_directed: lat=%0d won=%0b reads=%p want 14 1 %p",
               obs_lat, obs_won, got_q, want);
    end
  endtask

  task automatic test_split();
    logic [W-1:0] want[$];
    want = '{ {3'd4, 3'd2}, {3'd5, 3'd2}, {3'd2, 3'd2}, {3'd1, 3'd2} };
    clear_board();
    board[1][2] = 2'b10; board[2][2] = 2'b10; board[3][2] = 2'b10; board[4][2] = 2'b10;
    run_scan("split", 3, 2, 1'b1, 0);
    checks++;
    if (obs_lat !== 10 || obs_won !== 1'b1 || got_q != want) begin
      errors++;
      $display("FAIL split_directed: lat=%0d won=%0b reads=%p want 10 1 %p",
               obs_lat, obs_won, got_q, want);
    end
  endtask

  task automatic test_block();
    clear_board();
    board[1][2] = 2'b10; board[2][2] = 2'b10; board[3][2] = 2'b10; board[4][2] = 2'b01;
    run_scan("block", 3, 2, 1'b1, 0);
    checks++;
    if (obs_won !== 1'b0) begin
      errors++;
      $display("FAIL block_directed: has_won=%0b want 0", obs_won);
    end
  endtask

  task automatic test_illegal();
    clear_board();
    run_scan("illegal_col", 7, 0, 1'b0, 0);
    checks++;
    if (obs_lat !== 2 || got_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_col_directed: lat=%0d reads=%0d want 2 0", obs_lat, got_q.size());
    end
    run_scan("illegal_row", 2, 6, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    clear_board();
    board[0][0] = 2'b10; board[1][1] = 2'b10; board[2][2] = 2'b10; board[3][3] = 2'b10;
    run_scan("busy_restart", 2, 2, 1'b1, 3);
    run_scan("after_restart", 3, 3, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_board();
    last_col = 3'd0; last_row = 3'd0; turn = 1'b0;
    check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read: rd_en=%0b want 1", rd_en);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || has_won !== 1'b0 ||
        rd_col !== 3'd0 || rd_row !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_async: rd_en=%0b busy=%0b done=%0b won=%0b want all 0",
               rd_en, busy, done, has_won);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy, want 0", bad);
    end
    board[0][1] = 2'b01; board[0][2] = 2'b01; board[0][3] = 2'b01; board[0][0] = 2'b01;
    run_scan("post_reset", 0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int lc, lr, v;
    logic t;
    for (int n = 0; n < 60; n++) begin
      t = 1'($urandom_range(0, 1));
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++) begin
          v = $urandom_range(0, 3);
          board[c][r] = (v == 0) ? 2'b00 : (v == 3) ? (t ? 2'b01 : 2'b10) : (t ? 2'b10 : 2'b01);
        end
      lc = $urandom_range(0, COLS - 1);
      lr = $urandom_range(0, ROWS - 1);
      if ($urandom_range(0, 9) == 0) lc = 7;
      if (lc < COLS) board[lc][lr] = t ? 2'b10 : 2'b01;
      run_scan("random", lc, lr, t, 0);
    end
  endtask

  initial begin
    clear_board();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_empty();
    test_vertical();
    test_split();
    test_block();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
